// File: rtl/spi_pkg.sv
// Shared types and default sizing for the mode-0 SPI master controller.
package spi_pkg;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_CLK_DIV    = 4;

   typedef enum logic [2:0] {IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD, DONE} spi_state_e;
endpackage

// File: rtl/spi_shift_reg.sv
// Full-duplex shift register: parallel load or MSB-first left shift, load wins.
module spi_shift_reg
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_sh,
   input  logic                  i_ld,
   input  logic [DATA_WIDTH-1:0] i_d_par_in,
   input  logic                  i_d_ser_in,
   output logic                  o_d_ser_out,
   output logic [DATA_WIDTH-1:0] o_d_par_out
);
   logic [DATA_WIDTH-1:0] r_sr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_sr <= '0;
      else if (i_ld)
         r_sr <= i_d_par_in;
      else if (i_sh)
         r_sr <= {r_sr[DATA_WIDTH-2:0], i_d_ser_in};
   end

   assign o_d_ser_out = r_sr[DATA_WIDTH-1];
   assign o_d_par_out = r_sr;
endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: sequences one MSB-first full-duplex word per accepted start,
// driving registered SCLK/CS_N and strobing the shift-register datapath.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CLK_DIV    = DEF_CLK_DIV
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_rx_data,
   output logic                  o_sclk,
   output logic                  o_cs_n,
   output logic                  o_mosi,
   input  logic                  i_miso
);
   localparam int DIV_W = $clog2(CLK_DIV + 1);
   localparam int BIT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_ALL  = BIT_W'(DATA_WIDTH);

   spi_state_e            r_state;
   logic [DIV_W-1:0]      r_div_cnt;
   logic [BIT_W-1:0]      r_bit_cnt;
   logic                  r_sample;
   logic                  r_sclk;
   logic                  r_cs_n;
   logic                  r_busy;
   logic                  r_done;
   logic [DATA_WIDTH-1:0] r_rx_data;

   logic                  w_ld;
   logic                  w_sh;
   logic                  w_first;
   logic                  w_last;
   logic [BIT_W-1:0]      w_bit_cnt_eff;
   logic [DATA_WIDTH-1:0] w_sr;

   assign w_first = (r_div_cnt == DIV_LAST);
   assign w_last  = (r_div_cnt == '0);
   assign w_ld    = (r_state == IDLE) && i_start;
   assign w_sh    = (r_state == SCLK_LO) && w_first;
   // With CLK_DIV=1 the shift cycle is also the exit cycle, so count the bit in flight.
   assign w_bit_cnt_eff = w_sh ? r_bit_cnt + 1'b1 : r_bit_cnt;

   spi_shift_reg #(.DATA_WIDTH(DATA_WIDTH)) u_sr (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_sh        (w_sh),
      .i_ld        (w_ld),
      .i_d_par_in  (i_tx_data),
      .i_d_ser_in  (r_sample),
      .o_d_ser_out (o_mosi),
      .o_d_par_out (w_sr)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_div_cnt <= '0;
         r_bit_cnt <= '0;
         r_sample  <= 1'b0;
         r_sclk    <= 1'b0;
         r_cs_n    <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_rx_data <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_state   <= SETUP;
                  r_div_cnt <= DIV_LAST;
                  r_bit_cnt <= '0;
                  r_busy    <= 1'b1;
                  r_cs_n    <= 1'b0;
               end
            end
            SETUP: begin
               if (w_last) begin
                  r_state   <= SCLK_HI;
                  r_div_cnt <= DIV_LAST;
                  r_sclk    <= 1'b1;
               end else
                  r_div_cnt <= r_div_cnt - 1'b1;
            end
            SCLK_HI: begin
               if (w_first)
                  r_sample <= i_miso;
               if (w_last) begin
                  r_state   <= SCLK_LO;
                  r_div_cnt <= DIV_LAST;
                  r_sclk    <= 1'b0;
               end else
                  r_div_cnt <= r_div_cnt - 1'b1;
            end
            SCLK_LO: begin
               r_bit_cnt <= w_bit_cnt_eff;
               if (w_last) begin
                  r_div_cnt <= DIV_LAST;
                  if (w_bit_cnt_eff == BIT_ALL)
                     r_state <= HOLD;
                  else begin
                     r_state <= SCLK_HI;
                     r_sclk  <= 1'b1;
                  end
               end else
                  r_div_cnt <= r_div_cnt - 1'b1;
            end
            HOLD: begin
               if (w_last) begin
                  r_state   <= DONE;
                  r_div_cnt <= '0;
                  r_cs_n    <= 1'b1;
                  r_done    <= 1'b1;
                  r_rx_data <= w_sr;
               end else
                  r_div_cnt <= r_div_cnt - 1'b1;
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_sclk  <= 1'b0;
               r_cs_n  <= 1'b1;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_rx_data = r_rx_data;
   assign o_sclk    = r_sclk;
   assign o_cs_n    = r_cs_n;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: three configurations, a mode-0 slave model and
// latency/data expectations derived from the transfer timing rules.
module tb_spi_master_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // A: W=8, CLK_DIV=2 with slave model or loopback
   logic       a_start = 0, a_busy, a_done, a_sclk, a_cs_n, a_mosi, a_miso;
   logic [7:0] a_tx = '0, a_rx;
   bit         a_loop = 1'b1;
   logic [7:0] a_slave_tx = '0;
   // B: W=8, CLK_DIV=1 loopback
   logic       b_start = 0, b_busy, b_done, b_sclk, b_cs_n, b_mosi;
   logic [7:0] b_tx = '0, b_rx;
   // C: W=16, CLK_DIV=1 loopback
   logic        c_start = 0, c_busy, c_done, c_sclk, c_cs_n, c_mosi;
   logic [15:0] c_tx = '0, c_rx;

   logic       sl_out = 1'b0;
   logic [7:0] sl_rx = '0;
   int         sl_idx = 0, sl_rises = 0, mosi_bad = 0;

   assign a_miso = a_loop ? a_mosi : sl_out;

   spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(2)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_tx_data(a_tx), .o_busy(a_busy),
      .o_done(a_done), .o_rx_data(a_rx), .o_sclk(a_sclk), .o_cs_n(a_cs_n),
      .o_mosi(a_mosi), .i_miso(a_miso));
   spi_master_ctrl #(.DATA_WIDTH(8), .CLK_DIV(1)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_tx_data(b_tx), .o_busy(b_busy),
      .o_done(b_done), .o_rx_data(b_rx), .o_sclk(b_sclk), .o_cs_n(b_cs_n),
      .o_mosi(b_mosi), .i_miso(b_mosi));
   spi_master_ctrl #(.DATA_WIDTH(16), .CLK_DIV(1)) dut_c (
      .i_clk(clk), .i_rst(rst), .i_start(c_start), .i_tx_data(c_tx), .o_busy(c_busy),
      .o_done(c_done), .o_rx_data(c_rx), .o_sclk(c_sclk), .o_cs_n(c_cs_n),
      .o_mosi(c_mosi), .i_miso(c_mosi));

   // Mode-0 slave: captures mosi on sclk rise, presents next bit after sclk fall
   always @(negedge a_cs_n) begin
      sl_idx = 0; sl_rx = '0; sl_rises = 0; sl_out = a_slave_tx[7];
   end
   always @(posedge a_sclk) if (!a_cs_n) begin
      sl_rx = {sl_rx[6:0], a_mosi}; sl_rises++;
   end
   always @(negedge a_sclk) if (!a_cs_n) begin
      sl_idx++;
      #1;
      sl_out = (sl_idx < 8) ? a_slave_tx[3'(7 - sl_idx)] : 1'b0;
   end
   always @(a_mosi) if (!a_cs_n && a_sclk) mosi_bad++;

   function automatic int lat_model(input int w, input int div);
      return 1 + div * (2 * w + 2);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic get_done(input int w);
      case (w) 0: return a_done; 1: return b_done; default: return c_done; endcase
   endfunction
   function automatic logic get_cs(input int w);
      case (w) 0: return a_cs_n; 1: return b_cs_n; default: return c_cs_n; endcase
   endfunction
   function automatic logic [15:0] get_rx(input int w);
      case (w) 0: return {8'h00, a_rx}; 1: return {8'h00, b_rx}; default: return c_rx; endcase
   endfunction
   task automatic set_start(input int w, input logic v);
      case (w) 0: a_start = v; 1: b_start = v; default: c_start = v; endcase
   endtask
   task automatic set_tx(input int w, input logic [15:0] v);
      case (w) 0: a_tx = v[7:0]; 1: b_tx = v[7:0]; default: c_tx = v; endcase
   endtask

   // One transfer; window bounded a few cycles past the expected done.
   task automatic xfer(input int w, input logic [15:0] tx, input int exp_lat, input bit repulse,
                       output int dones, output int lat, output int cs_low, output logic [15:0] rx);
      @(negedge clk);
      set_tx(w, tx);
      set_start(w, 1'b1);
      dones = 0; lat = -1; cs_low = 0; rx = '0;
      for (int cyc = 1; cyc <= exp_lat + 12; cyc++) begin
         @(posedge clk);
         #1;
         set_start(w, repulse && (cyc == 5 || cyc == 20));
         if (repulse && cyc == 3) set_tx(w, 16'hFFFF);
         if (!get_cs(w)) cs_low++;
         if (get_done(w)) begin
            dones++;
            if (lat < 0) begin lat = cyc; rx = get_rx(w); end
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int dones, lat, cs_low, t[3], nd, busy_lo, cs_hi, la;
      logic [15:0] rx, tx, sl, rxs[3];
      bit lp;
      la = lat_model(8, 2);

      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",  {a_busy, b_busy, c_busy}, 3'b000);
      chk("rst_done",  {a_done, b_done, c_done}, 3'b000);
      chk("rst_cs_n",  {a_cs_n, b_cs_n, c_cs_n}, 3'b111);
      chk("rst_sclk",  {a_sclk, b_sclk, c_sclk}, 3'b000);
      chk("rst_rx_a",  a_rx, 0);
      chk("rst_rx_c",  c_rx, 0);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);

      // Loopback 8'hA5
      a_loop = 1'b1;
      xfer(0, 16'h00A5, la, 1'b0, dones, lat, cs_low, rx);
      $display("[TB] A loopback tx=a5 rx=%h lat=%0d cs_low=%0d rises=%0d", rx[7:0], lat, cs_low, sl_rises);
      chk("a5_latency", lat, la);
      chk("a5_rx", rx, 16'h00A5);
      chk("a5_sclk_rises", sl_rises, 8);
      chk("a5_cs_low", cs_low, la - 1);
      chk("a5_one_done", dones, 1);

      // Slave returns 3C while master sends C3
      a_loop = 1'b0; a_slave_tx = 8'h3C; mosi_bad = 0;
      xfer(0, 16'h00C3, la, 1'b0, dones, lat, cs_low, rx);
      $display("[TB] A slave tx=c3 slave_rx=%h rx=%h lat=%0d", sl_rx, rx[7:0], lat);
      chk("c3_slave_rx", sl_rx, 8'hC3);
      chk("c3_rx", rx, 16'h003C);
      chk("c3_mosi_stable", mosi_bad, 0);
      chk("c3_latency", lat, la);

      // Re-pulsed start and late tx_data change
      a_slave_tx = 8'h96;
      xfer(0, 16'h005E, la, 1'b1, dones, lat, cs_low, rx);
      $display("[TB] A repulse slave_rx=%h rx=%h dones=%0d", sl_rx, rx[7:0], dones);
      chk("rep_one_done", dones, 1);
      chk("rep_slave_rx", sl_rx, 8'h5E);
      chk("rep_rx", rx, 16'h0096);
      chk("rep_latency", lat, la);

      // Randomized words, random loopback/slave choice
      for (int k = 0; k < 6; k++) begin
         tx = 16'($urandom_range(0, 255));
         sl = 16'($urandom_range(0, 255));
         lp = 1'($urandom_range(0, 1));
         a_loop = lp; a_slave_tx = sl[7:0]; mosi_bad = 0;
         xfer(0, tx, la, 1'b0, dones, lat, cs_low, rx);
         $display("[TB] A rand%0d tx=%h slave=%h loop=%0d rx=%h lat=%0d", k, tx[7:0], sl[7:0], lp, rx[7:0], lat);
         chk("rand_rx", rx, lp ? tx : sl);
         chk("rand_latency", lat, la);
         chk("rand_mosi_stable", mosi_bad, 0);
         if (!lp) chk("rand_slave_rx", sl_rx, tx[7:0]);
      end

      // Asynchronous reset at cycle 15 of a transfer
      a_loop = 1'b1;
      xfer(0, 16'h0081, la, 1'b0, dones, lat, cs_low, rx);
      chk("pre_rst_rx", rx, 16'h0081);
      @(negedge clk);
      a_tx = 8'h6D; a_start = 1'b1;
      @(posedge clk); #1 a_start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      chk("mid_busy_before", a_busy, 1'b1);
      rst = 1'b1;
      #1;
      $display("[TB] A reset@15 cs_n=%0d sclk=%0d busy=%0d rx=%h", a_cs_n, a_sclk, a_busy, a_rx);
      chk("mid_rst_cs_n", a_cs_n, 1'b1);
      chk("mid_rst_sclk", a_sclk, 1'b0);
      chk("mid_rst_busy", a_busy, 1'b0);
      chk("mid_rst_rx", a_rx, 0);
      nd = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (k == 2) rst = 1'b0;
         if (a_done) nd++;
      end
      chk("mid_rst_no_done", nd, 0);
      a_loop = 1'b0; a_slave_tx = 8'hE7;
      xfer(0, 16'h0019, la, 1'b0, dones, lat, cs_low, rx);
      $display("[TB] A post-reset slave_rx=%h rx=%h lat=%0d", sl_rx, rx[7:0], lat);
      chk("post_rst_rx", rx, 16'h00E7);
      chk("post_rst_slave_rx", sl_rx, 8'h19);
      chk("post_rst_latency", lat, la);

      // Back-to-back with start held, CLK_DIV=1
      @(negedge clk);
      tx = 16'($urandom_range(1, 255));
      b_tx = tx[7:0]; b_start = 1'b1;
      nd = 0; busy_lo = 0; cs_hi = 0;
      for (int cyc = 1; cyc <= 90; cyc++) begin
         @(posedge clk); #1;
         if (nd >= 1 && nd < 3 && !b_busy) busy_lo++;
         if (nd >= 1 && nd < 3 && b_cs_n) cs_hi++;
         if (b_done && nd < 3) begin t[nd] = cyc; rxs[nd] = {8'h00, b_rx}; nd++; end
         if (nd == 3) b_start = 1'b0;
      end
      $display("[TB] B b2b tx=%h dones=%0d t=%0d,%0d,%0d busy_lo=%0d cs_hi=%0d", tx[7:0], nd, t[0], t[1], t[2], busy_lo, cs_hi);
      chk("b2b_count", nd, 3);
      chk("b2b_first", t[0], lat_model(8, 1));
      chk("b2b_period1", t[1] - t[0], lat_model(8, 1) + 1);
      chk("b2b_period2", t[2] - t[1], lat_model(8, 1) + 1);
      for (int k = 0; k < 3; k++) chk("b2b_rx", rxs[k], tx);
      chk("b2b_idle_cycles", busy_lo, 2);
      chk("b2b_cs_gap", cs_hi >= 2, 1'b1);

      // W=16, CLK_DIV=1 loopback
      xfer(2, 16'h8001, lat_model(16, 1), 1'b0, dones, lat, cs_low, rx);
      $display("[TB] C w16 tx=8001 rx=%h lat=%0d", rx, lat);
      chk("w16_latency", lat, lat_model(16, 1));
      chk("w16_rx", rx, 16'h8001);
      tx = 16'($urandom);
      xfer(2, tx, lat_model(16, 1), 1'b0, dones, lat, cs_low, rx);
      $display("[TB] C w16 tx=%h rx=%h lat=%0d", tx, rx, lat);
      chk("w16_rand_rx", rx, tx);
      chk("w16_rand_cs_low", cs_low, lat_model(16, 1) - 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
